// File: rtl/writeback_arbiter.sv
// ---------------------------------------------------------------------------
// writeback_arbiter
//
// Merges ALU results and load results onto the single register-file write
// port (we3/a3/wd3). There is one write per cycle, chosen by fixed priority:
//   1. ALU result (rd != 0)
//   2. head of the 2-entry load FIFO (popped)
//   3. load result that bypasses an empty FIFO
// A load that cannot be written in the cycle it is accepted goes into the
// FIFO. Results with rd == 0 are dropped. A load with rd == 0 is still
// accepted, so it is consumed without being written.
//
// Handshake (load side): a load transfers on a rising edge of clk when
// mem_valid && mem_ready are both high. mem_ready depends only on state and
// rst. It never looks at mem_valid. The ALU side has no backpressure: an
// ALU result is taken in every cycle where alu_valid is high.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   alu_valid, alu_rd, alu_data    ALU result
//   mem_valid, mem_rd, mem_data    load result offered
//   mem_ready                      load accepted when mem_valid && mem_ready
//   we3, a3, wd3                   registered register-file write port
//   pend_cnt                       load FIFO occupancy (0..2)
//   stall_req                      FIFO full; upstream must hold alu_valid low
//
// Optional feature, macro WB_FORWARD_EN:
//   a1, a2                         read addresses to forward for
//   fwd1_hit/fwd1_data,
//   fwd2_hit/fwd2_data             newest pending value for a1/a2.
//                                  Priority: FIFO tail, FIFO head, write port.
// ---------------------------------------------------------------------------
module writeback_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [5:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        mem_valid,
  input  logic [5:0]  mem_rd,
  input  logic [31:0] mem_data,
  output logic        mem_ready,
  output logic        we3,
  output logic [5:0]  a3,
  output logic [31:0] wd3,
  output logic [1:0]  pend_cnt,
  output logic        stall_req
`ifdef WB_FORWARD_EN
  ,
  input  logic [5:0]  a1,
  input  logic [5:0]  a2,
  output logic        fwd1_hit,
  output logic [31:0] fwd1_data,
  output logic        fwd2_hit,
  output logic [31:0] fwd2_data
`endif
);

  // FIFO storage. There is no reset here: the contents are only meaningful
  // where r_cnt says so.
  logic [5:0]  r_fifo_rd   [2];
  logic [31:0] r_fifo_data [2];
  logic        r_head;
  logic [1:0]  r_cnt;

  logic        w_fifo_empty;
  logic        w_fifo_full;
  logic        w_alu_take;
  logic        w_mem_acc;
  logic        w_mem_keep;
  logic        w_pop;
  logic        w_bypass;
  logic        w_push;
  logic        w_push_idx;
  logic        w_we_nxt;
  logic [5:0]  w_a_nxt;
  logic [31:0] w_d_nxt;

  assign w_fifo_empty = (r_cnt == 2'd0);
  assign w_fifo_full  = (r_cnt == 2'd2);

  assign mem_ready = !w_fifo_full && !rst;
  assign stall_req = w_fifo_full && !rst;
  assign pend_cnt  = r_cnt;

  // When rst is high, mem_ready is low. So nothing is accepted, pushed or
  // bypassed. The ALU path is blocked by the reset branch of the register.
  assign w_alu_take = alu_valid && (alu_rd != 6'd0);
  assign w_mem_acc  = mem_valid && mem_ready;
  assign w_mem_keep = w_mem_acc && (mem_rd != 6'd0);

  assign w_pop    = !w_alu_take && !w_fifo_empty;
  assign w_bypass = !w_alu_take && w_fifo_empty && w_mem_keep;
  assign w_push   = w_mem_keep && !w_bypass;

  // The slot after the last valid entry. Because the FIFO has depth 2, this
  // is head + cnt mod 2. A push can only happen when cnt < 2.
  assign w_push_idx = r_head ^ r_cnt[0];

  always_comb begin
    w_we_nxt = 1'b0;
    w_a_nxt  = a3;
    w_d_nxt  = wd3;
    if (w_alu_take) begin
      w_we_nxt = 1'b1;
      w_a_nxt  = alu_rd;
      w_d_nxt  = alu_data;
    end else if (w_pop) begin
      w_we_nxt = 1'b1;
      w_a_nxt  = r_fifo_rd[r_head];
      w_d_nxt  = r_fifo_data[r_head];
    end else if (w_bypass) begin
      w_we_nxt = 1'b1;
      w_a_nxt  = mem_rd;
      w_d_nxt  = mem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we3    <= 1'b0;
      a3     <= 6'd0;
      wd3    <= 32'd0;
      r_cnt  <= 2'd0;
      r_head <= 1'b0;
    end else begin
      we3 <= w_we_nxt;
      a3  <= w_a_nxt;
      wd3 <= w_d_nxt;
      if (w_pop) begin
        r_head <= ~r_head;
      end
      if (w_push && !w_pop) begin
        r_cnt <= r_cnt + 2'd1;
      end else if (w_pop && !w_push) begin
        r_cnt <= r_cnt - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_rd[w_push_idx]   <= mem_rd;
      r_fifo_data[w_push_idx] <= mem_data;
    end
  end

`ifdef WB_FORWARD_EN
  // The tail is the newest entry: head when cnt == 1, and head^1 when
  // cnt == 2. Checking the tail first makes the youngest value win when
  // both entries hold the same rd.
  logic w_tail_idx;
  assign w_tail_idx = r_head ^ r_cnt[1];

  function automatic logic [32:0] fwd_lookup(input logic [5:0] addr);
    logic [32:0] res;
    res = 33'd0;
    if (addr != 6'd0) begin
      if (!w_fifo_empty && (r_fifo_rd[w_tail_idx] == addr)) begin
        res = {1'b1, r_fifo_data[w_tail_idx]};
      end else if (!w_fifo_empty && (r_fifo_rd[r_head] == addr)) begin
        res = {1'b1, r_fifo_data[r_head]};
      end else if (we3 && (a3 == addr)) begin
        res = {1'b1, wd3};
      end
    end
    return res;
  endfunction

  always_comb begin
    {fwd1_hit, fwd1_data} = fwd_lookup(a1);
    {fwd2_hit, fwd2_data} = fwd_lookup(a2);
  end
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
module tb_writeback_arbiter;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic [5:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic [5:0]  mem_rd;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        we3;
  logic [5:0]  a3;
  logic [31:0] wd3;
  logic [1:0]  pend_cnt;
  logic        stall_req;
`ifdef WB_FORWARD_EN
  logic [5:0]  a1;
  logic [5:0]  a2;
  logic        fwd1_hit;
  logic [31:0] fwd1_data;
  logic        fwd2_hit;
  logic [31:0] fwd2_data;
`endif

  int tests = 0;
  int fails = 0;

  // Reference model: the pending loads in arrival order, {rd, data}, plus
  // the write-port value expected after the next edge.
  logic [37:0] exp_q[$];
  logic        exp_we;
  logic [5:0]  exp_a;
  logic [31:0] exp_d;

  writeback_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .mem_valid (mem_valid),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .we3       (we3),
    .a3        (a3),
    .wd3       (wd3),
    .pend_cnt  (pend_cnt),
    .stall_req (stall_req)
`ifdef WB_FORWARD_EN
    ,
    .a1        (a1),
    .a2        (a2),
    .fwd1_hit  (fwd1_hit),
    .fwd1_data (fwd1_data),
    .fwd2_hit  (fwd2_hit),
    .fwd2_data (fwd2_data)
`endif
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

`ifdef WB_FORWARD_EN
  // Newest pending value for addr: FIFO tail, then FIFO head, then write port.
  function automatic logic [32:0] fwd_model(input logic [5:0] addr);
    if (addr == 6'd0) return 33'd0;
    for (int i = exp_q.size() - 1; i >= 0; i--)
      if (exp_q[i][37:32] == addr) return {1'b1, exp_q[i][31:0]};
    if (exp_we && exp_a == addr) return {1'b1, exp_d};
    return 33'd0;
  endfunction
`endif

  // One clock cycle with the inputs as currently driven. Checks the
  // combinational outputs, advances the model, then checks the write port.
  task automatic cycle();
    int    n;
    bit    alu_take;
    bit    keep;
    bit    have;
    logic [37:0] ent;
    #1;
    n = exp_q.size();
    chk("pend_cnt", pend_cnt, n[1:0]);
    chk("mem_ready", mem_ready, !rst && n != 2);
    chk("stall_req", stall_req, !rst && n == 2);
`ifdef WB_FORWARD_EN
    chk("fwd1", {fwd1_hit, fwd1_data}, fwd_model(a1));
    chk("fwd2", {fwd2_hit, fwd2_data}, fwd_model(a2));
`endif
    if (rst) begin
      exp_q.delete();
      exp_we = 1'b0;
      exp_a  = 6'd0;
      exp_d  = 32'd0;
    end else begin
      alu_take = alu_valid && alu_rd != 0;
      keep     = mem_valid && n < 2 && mem_rd != 0;
      have     = 1'b1;
      if (alu_take) ent = {alu_rd, alu_data};
      else if (n > 0) ent = exp_q.pop_front();
      else if (keep) begin
        ent  = {mem_rd, mem_data};
        keep = 1'b0;
      end else have = 1'b0;
      if (keep) exp_q.push_back({mem_rd, mem_data});
      exp_we = have;
      if (have) begin
        exp_a = ent[37:32];
        exp_d = ent[31:0];
      end
    end
    @(posedge clk);
    #1;
    chk("we3", we3, exp_we);
    if (exp_we || rst) begin
      chk("a3", a3, exp_a);
      chk("wd3", wd3, exp_d);
    end
  endtask

  // driver
  task automatic drive(input bit av, input logic [5:0] ard, input logic [31:0] ad,
                       input bit mv, input logic [5:0] mrd, input logic [31:0] md);
    alu_valid = av;
    alu_rd    = ard;
    alu_data  = ad;
    mem_valid = mv;
    mem_rd    = mrd;
    mem_data  = md;
    cycle();
  endtask

  initial begin
    rst = 1'b1;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    mem_valid = 0; mem_rd = 0; mem_data = 0;
`ifdef WB_FORWARD_EN
    a1 = 0; a2 = 0;
`endif
    exp_we = 0; exp_a = 0; exp_d = 0;
    @(posedge clk);
    #1;
    // Reset state, with inputs that must be ignored.
    drive(1, 6'd9, 32'h1234, 1, 6'd9, 32'h5678);
    chk("reset_we3", we3, 1'b0);
    chk("reset_pend", pend_cnt, 2'd0);
    chk("reset_mem_ready", mem_ready, 1'b0);
    chk("reset_stall", stall_req, 1'b0);
    rst = 1'b0;

    // ALU result: one-cycle latency, present for a single cycle only.
    drive(1, 6'd5, 32'hDEADBEEF, 0, 6'd0, 32'd0);
    chk("alu_we3", we3, 1'b1);
    chk("alu_a3", a3, 6'd5);
    chk("alu_wd3", wd3, 32'hDEADBEEF);
    drive(0, 6'd0, 32'd0, 0, 6'd0, 32'd0);
    chk("alu_one_cycle", we3, 1'b0);

    // Load bypass into an empty FIFO.
    drive(0, 6'd0, 32'd0, 1, 6'd7, 32'h11);
    chk("bypass_a3", a3, 6'd7);
    chk("bypass_wd3", wd3, 32'h11);
    chk("bypass_pend", pend_cnt, 2'd0);

    // ALU holds the port while two loads queue, then the loads drain in order.
    drive(1, 6'd10, 32'h1, 1, 6'd8, 32'h80);
    drive(1, 6'd11, 32'h2, 1, 6'd9, 32'h90);
    drive(1, 6'd12, 32'h3, 0, 6'd0, 32'd0);
    chk("full_pend", pend_cnt, 2'd2);
    chk("full_mem_ready", mem_ready, 1'b0);
    chk("full_stall", stall_req, 1'b1);
    drive(1, 6'd13, 32'h4, 1, 6'd14, 32'hEE);  // offered while full: not taken
    drive(0, 6'd0, 32'd0, 0, 6'd0, 32'd0);
    chk("drain1_a3", a3, 6'd8);
    drive(0, 6'd0, 32'd0, 0, 6'd0, 32'd0);
    chk("drain2_a3", a3, 6'd9);
    chk("drain_pend", pend_cnt, 2'd0);

    // An ALU result with rd=0 gives the slot to the FIFO head.
    drive(1, 6'd1, 32'h100, 1, 6'd3, 32'h33);
    drive(1, 6'd0, 32'h5, 0, 6'd0, 32'd0);
    chk("rd0_we3", we3, 1'b1);
    chk("rd0_a3", a3, 6'd3);

    // A load with rd=0 is accepted and then discarded.
    drive(0, 6'd0, 32'd0, 1, 6'd0, 32'h77);
    chk("ld_rd0_we3", we3, 1'b0);

    // Reset in mid-operation discards the queued loads.
    drive(1, 6'd1, 32'h1, 1, 6'd20, 32'h20);
    drive(1, 6'd2, 32'h2, 1, 6'd21, 32'h21);
    chk("pre_rst_pend", pend_cnt, 2'd2);
    rst = 1'b1;
    drive(0, 6'd0, 32'd0, 0, 6'd0, 32'd0);
    rst = 1'b0;
    chk("rst_we3", we3, 1'b0);
    chk("rst_pend", pend_cnt, 2'd0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 6'd0, 32'd0, 0, 6'd0, 32'd0);
      chk("post_rst_we3", we3, 1'b0);
    end

`ifdef WB_FORWARD_EN
    // When the same rd is in both entries, the tail wins.
    drive(1, 6'd1, 32'h1, 1, 6'd4, 32'hA);
    drive(1, 6'd2, 32'h2, 1, 6'd4, 32'hB);
    a1 = 6'd4;
    a2 = 6'd0;
    #1;
    chk("fwd1_hit", fwd1_hit, 1'b1);
    chk("fwd1_data", fwd1_data, 32'hB);
    chk("fwd2_hit", fwd2_hit, 1'b0);
    chk("fwd2_data", fwd2_data, 32'h0);
`endif

    // Random traffic. The upstream pipeline holds alu_valid low while the
    // FIFO is full.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
`ifdef WB_FORWARD_EN
      a1 = 6'($urandom_range(0, 7));
      a2 = 6'($urandom_range(0, 7));
`endif
      drive(($urandom_range(0, 3) != 0) && (exp_q.size() != 2),
            6'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 1) == 1,
            6'($urandom_range(0, 7)), $urandom);
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
